estagio_writeback: RTL and testbench

//  MEM/WB pipeline register and write-back formatter; drives the register-file write port (rd, data, IR_W).

---
 rtl/estagio_writeback.sv | 134 +++++++++++++
 tb/tb_estagio_writeback.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/estagio_writeback.sv
// MEM/WB pipeline register: decodes the instruction leaving MEM, formats load data,
// gates the register-file write enable and counts retired instructions.
module estagio_writeback #(
  parameter int          CNT_W    = 32,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input  logic              wb_in_clk,
  input  logic              wb_in_reset_n,
  input  logic              wb_in_stall,
  input  logic              wb_in_flush,
  input  logic              wb_in_valid,
  input  logic [31:0]       wb_in_IR_M,
  input  logic [31:0]       wb_in_alu_result,
  input  logic [31:0]       wb_in_mem_data,
  input  logic [31:0]       wb_in_pc_plus8,
  output logic [4:0]        wb_out_rd,
  output logic [31:0]       wb_out_data,
  output logic              wb_out_we,
  output logic [31:0]       wb_out_IR_W,
  output logic              wb_out_misaligned,
  output logic [CNT_W-1:0]  wb_out_retired
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [1:0]  byte_off;
  logic [4:0]  dest;
  logic [31:0] wdata;
  logic        writes_reg;
  logic        misal;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        next_we;

  assign op       = wb_in_IR_M[31:26];
  assign funct    = wb_in_IR_M[5:0];
  assign byte_off = wb_in_alu_result[1:0];

  // little-endian lane selection for sub-word loads
  always_comb begin
    lane_half = byte_off[1] ? wb_in_mem_data[31:16] : wb_in_mem_data[15:0];
    case (byte_off)
      2'd0:    lane_byte = wb_in_mem_data[7:0];
      2'd1:    lane_byte = wb_in_mem_data[15:8];
      2'd2:    lane_byte = wb_in_mem_data[23:16];
      2'd3:    lane_byte = wb_in_mem_data[31:24];
      default: lane_byte = 8'd0;
    endcase
  end

  // instruction decode: destination, write data, write intent, alignment fault
  always_comb begin
    dest       = 5'd0;
    wdata      = 32'd0;
    writes_reg = 1'b0;
    misal      = 1'b0;
    case (op)
      6'h00: begin
        dest       = wb_in_IR_M[15:11];
        wdata      = wb_in_alu_result;
        writes_reg = (funct != 6'h08);
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        dest       = wb_in_IR_M[20:16];
        wdata      = wb_in_alu_result;
        writes_reg = 1'b1;
      end
      6'h03: begin
        dest       = LINK_REG;
        wdata      = wb_in_pc_plus8;
        writes_reg = 1'b1;
      end
      6'h23: begin
        dest       = wb_in_IR_M[20:16];
        wdata      = wb_in_mem_data;
        writes_reg = 1'b1;
        misal      = (byte_off != 2'd0);
      end
      6'h21, 6'h25: begin
        dest       = wb_in_IR_M[20:16];
        writes_reg = 1'b1;
        misal      = byte_off[0];
        if (op == 6'h21) begin
          wdata = {{16{lane_half[15]}}, lane_half};
        end else begin
          wdata = {16'd0, lane_half};
        end
      end
      6'h20, 6'h24: begin
        dest       = wb_in_IR_M[20:16];
        writes_reg = 1'b1;
        if (op == 6'h20) begin
          wdata = {{24{lane_byte[7]}}, lane_byte};
        end else begin
          wdata = {24'd0, lane_byte};
        end
      end
      default: begin
        dest       = 5'd0;
        wdata      = 32'd0;
        writes_reg = 1'b0;
        misal      = 1'b0;
      end
    endcase
  end

  assign next_we = writes_reg & ~misal & (dest != 5'd0);

  // WB register: flush > stall > load; an invalid slot loads as a bubble
  always_ff @(posedge wb_in_clk or negedge wb_in_reset_n) begin
    if (!wb_in_reset_n) begin
      wb_out_rd         <= 5'd0;
      wb_out_data       <= 32'd0;
      wb_out_we         <= 1'b0;
      wb_out_IR_W       <= 32'd0;
      wb_out_misaligned <= 1'b0;
      wb_out_retired    <= {CNT_W{1'b0}};
    end else if (wb_in_flush || (!wb_in_stall && !wb_in_valid)) begin
      wb_out_rd         <= 5'd0;
      wb_out_data       <= 32'd0;
      wb_out_we         <= 1'b0;
      wb_out_IR_W       <= 32'd0;
      wb_out_misaligned <= 1'b0;
    end else if (!wb_in_stall) begin
      wb_out_rd         <= dest;
      wb_out_data       <= wdata;
      wb_out_we         <= next_we;
      wb_out_IR_W       <= wb_in_IR_M;
      wb_out_misaligned <= misal;
      wb_out_retired    <= wb_out_retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_estagio_writeback.sv
// Self-checking bench for estagio_writeback: directed table, hand sequences and
// randomized traffic against a behavioural model; a 4-bit-counter copy checks wrap.
module tb_estagio_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, valid = 1'b0;
  logic [31:0] ir = 32'd0, alu = 32'd0, mem = 32'd0, pc8 = 32'd0;

  logic [4:0]  rd, rd4;
  logic [31:0] data, data4, ir_w, ir_w4;
  logic        we, we4, mis, mis4;
  logic [31:0] retired;
  logic [3:0]  retired4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  estagio_writeback #(.CNT_W(32), .LINK_REG(5'd31)) dut (
    .wb_in_clk(clk), .wb_in_reset_n(rst_n), .wb_in_stall(stall), .wb_in_flush(flush),
    .wb_in_valid(valid), .wb_in_IR_M(ir), .wb_in_alu_result(alu), .wb_in_mem_data(mem),
    .wb_in_pc_plus8(pc8), .wb_out_rd(rd), .wb_out_data(data), .wb_out_we(we),
    .wb_out_IR_W(ir_w), .wb_out_misaligned(mis), .wb_out_retired(retired)
  );

  estagio_writeback #(.CNT_W(4), .LINK_REG(5'd31)) dut4 (
    .wb_in_clk(clk), .wb_in_reset_n(rst_n), .wb_in_stall(stall), .wb_in_flush(flush),
    .wb_in_valid(valid), .wb_in_IR_M(ir), .wb_in_alu_result(alu), .wb_in_mem_data(mem),
    .wb_in_pc_plus8(pc8), .wb_out_rd(rd4), .wb_out_data(data4), .wb_out_we(we4),
    .wb_out_IR_W(ir_w4), .wb_out_misaligned(mis4), .wb_out_retired(retired4)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic [31:0] irw;
    logic        chk_rd;
    logic        chk_data;
  } res_t;

  typedef struct {
    logic        valid;
    logic [31:0] ir, alu, mem, pc8;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        chk;
  } vec_t;

  res_t        exp_s;
  int unsigned exp_cnt;

  // behavioural reference: what the register file should see for one retiring instruction
  function automatic res_t ref_model(input logic [31:0] i, input logic [31:0] a32,
                                     input logic [31:0] m, input logic [31:0] p);
    res_t r;
    int op, a, b, h;
    logic wr;
    op = int'(i[31:26]);
    a  = int'(a32 % 32'd4);
    r = '{we: 1'b0, rd: 5'd0, data: 32'd0, mis: 1'b0, irw: i, chk_rd: 1'b0, chk_data: 1'b0};
    wr = 1'b0;
    if (op == 0) begin
      r.rd = i[15:11]; r.data = a32; wr = (i[5:0] != 6'd8);
      r.chk_rd = wr; r.chk_data = wr;
    end else if (op >= 8 && op <= 15) begin
      r.rd = i[20:16]; r.data = a32; wr = 1'b1; r.chk_rd = 1'b1; r.chk_data = 1'b1;
    end else if (op == 3) begin
      r.rd = 5'd31; r.data = p; wr = 1'b1; r.chk_rd = 1'b1; r.chk_data = 1'b1;
    end else if (op == 32 || op == 36) begin
      b = int'((m >> (8 * a)) & 32'hFF);
      r.rd = i[20:16]; wr = 1'b1; r.chk_rd = 1'b1; r.chk_data = 1'b1;
      r.data = (op == 32 && b >= 128) ? 32'(b) - 32'd256 : 32'(b);
    end else if (op == 33 || op == 37) begin
      h = int'((m >> (16 * (a / 2))) & 32'hFFFF);
      r.rd = i[20:16]; wr = 1'b1; r.mis = (a % 2 != 0); r.chk_rd = 1'b1;
      r.chk_data = !r.mis;
      r.data = (op == 33 && h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
    end else if (op == 35) begin
      r.rd = i[20:16]; r.data = m; wr = 1'b1; r.mis = (a != 0); r.chk_rd = 1'b1;
      r.chk_data = !r.mis;
    end
    r.we = wr && !r.mis && (r.rd != 5'd0);
    return r;
  endfunction

  function automatic res_t bubble();
    res_t r;
    r = '{we: 1'b0, rd: 5'd0, data: 32'd0, mis: 1'b0, irw: 32'd0, chk_rd: 1'b1, chk_data: 1'b1};
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    cmp({tag, ".we"}, {31'd0, we}, {31'd0, exp_s.we});
    cmp({tag, ".mis"}, {31'd0, mis}, {31'd0, exp_s.mis});
    cmp({tag, ".irw"}, ir_w, exp_s.irw);
    cmp({tag, ".retired"}, retired, exp_cnt);
    cmp({tag, ".retired4"}, {28'd0, retired4}, exp_cnt % 32'd16);
    if (exp_s.chk_rd) cmp({tag, ".rd"}, {27'd0, rd}, {27'd0, exp_s.rd});
    if (exp_s.chk_data) cmp({tag, ".data"}, data, exp_s.data);
  endtask

  // drive one cycle, advance the model, then sample just after the edge
  task automatic apply(input logic v, input logic s, input logic f, input logic [31:0] i,
                       input logic [31:0] a, input logic [31:0] m, input logic [31:0] p,
                       input string tag);
    valid = v; stall = s; flush = f; ir = i; alu = a; mem = m; pc8 = p;
    @(posedge clk);
    if (f) exp_s = bubble();
    else if (!s) begin
      if (v) begin exp_s = ref_model(i, a, m, p); exp_cnt++; end
      else exp_s = bubble();
    end
    #1;
    check_state(tag);
  endtask

  vec_t        tbl[$];
  logic [31:0] rir;
  logic [5:0]  ops[15];

  initial begin
    exp_s = bubble();
    exp_cnt = 0;
    #12;
    check_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    tbl.push_back('{1'b1, 32'h01095020, 32'h00001234, 32'h0, 32'h0, 1'b1, 5'd10, 32'h00001234, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 32'h80090000, 32'h00000003, 32'h80FF7F01, 32'h0, 1'b1, 5'd9, 32'hFFFFFF80, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 32'h90090000, 32'h00000003, 32'h80FF7F01, 32'h0, 1'b1, 5'd9, 32'h00000080, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 32'h84090000, 32'h00000002, 32'h80FF7F01, 32'h0, 1'b1, 5'd9, 32'hFFFF80FF, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 32'h94090000, 32'h00000002, 32'h80FF7F01, 32'h0, 1'b1, 5'd9, 32'h000080FF, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 32'h8C090000, 32'h00001000, 32'hDEADBEEF, 32'h0, 1'b1, 5'd9, 32'hDEADBEEF, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 32'h8C090000, 32'h00001002, 32'hDEADBEEF, 32'h0, 1'b0, 5'd9, 32'h0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 32'h94090000, 32'h00001001, 32'hDEADBEEF, 32'h0, 1'b0, 5'd9, 32'h0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 32'h0C000000, 32'h0, 32'h0, 32'h00400010, 1'b1, 5'd31, 32'h00400010, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 32'h20000000, 32'h00000005, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00000005, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 32'h01000008, 32'h00000077, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 32'hAC090000, 32'h00000010, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 32'h01095020, 32'h00001234, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1});

    foreach (tbl[k]) begin
      apply(tbl[k].valid, 1'b0, 1'b0, tbl[k].ir, tbl[k].alu, tbl[k].mem, tbl[k].pc8, $sformatf("tbl%0d", k));
      cmp($sformatf("tbl%0d.we_const", k), {31'd0, we}, {31'd0, tbl[k].we});
      cmp($sformatf("tbl%0d.mis_const", k), {31'd0, mis}, {31'd0, tbl[k].mis});
      if (tbl[k].chk) begin
        cmp($sformatf("tbl%0d.rd_const", k), {27'd0, rd}, {27'd0, tbl[k].rd});
        cmp($sformatf("tbl%0d.data_const", k), data, tbl[k].data);
      end
    end

    // stall freezes everything while inputs wander; flush beats stall
    apply(1'b1, 1'b0, 1'b0, 32'h01095020, 32'h0000ABCD, 32'h0, 32'h0, "pre_stall");
    for (int k = 0; k < 3; k++)
      apply(1'b1, 1'b1, 1'b0, 32'h0C000000 + 32'(k), 32'(k), 32'hFFFF_FFFF, 32'h1234, "stall");
    cmp("stall.rd_frozen", {27'd0, rd}, 32'd10);
    cmp("stall.data_frozen", data, 32'h0000ABCD);
    apply(1'b1, 1'b1, 1'b1, 32'h01095020, 32'h1, 32'h0, 32'h0, "flush_stall");
    cmp("flush_stall.we", {31'd0, we}, 32'd0);

    // asynchronous reset between edges clears at once
    apply(1'b1, 1'b0, 1'b0, 32'h01095020, 32'h00005555, 32'h0, 32'h0, "pre_reset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_s = bubble();
    exp_cnt = 0;
    check_state("async_reset");
    #2;
    rst_n = 1'b1;
    apply(1'b1, 1'b0, 1'b0, 32'h01095020, 32'h00000042, 32'h0, 32'h0, "post_reset");

    ops = '{6'h00, 6'h00, 6'h03, 6'h08, 6'h0D, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h2B, 6'h04, 6'h02, 6'h23};
    for (int n = 0; n < 400; n++) begin
      rir = $urandom;
      rir[31:26] = ops[$urandom_range(0, 14)];
      if (rir[31:26] == 6'h00 && $urandom_range(0, 4) == 0) rir[5:0] = 6'h08;
      if ($urandom_range(0, 9) == 0) begin rir[20:16] = 5'd0; rir[15:11] = 5'd0; end
      apply($urandom_range(0, 5) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
            rir, $urandom, $urandom, $urandom, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
